// File: rtl/mult_pipe_if.sv
// mult_pipe_if: issue-side / writeback-side signal bundle for mult_pipe.
//   master : driven by the issue stage (op, operands, stall/flush), sees the results.
//   slave  : the multiplier itself.
interface mult_pipe_if #(
    parameter int unsigned ARCH_BITS    = 32,
    parameter int unsigned STAGES       = 4,
    parameter int unsigned OPCODE_BITS  = 6,
    parameter int unsigned ROB_IDX_BITS = 4,
    parameter int unsigned REG_IDX_BITS = 5,
    parameter int unsigned CNT_BITS     = $clog2(STAGES + 1)
);
    // Issue side
    logic                    validIn;
    logic                    signedIn;
    logic [OPCODE_BITS-1:0]  opcodeIn;
    logic [ROB_IDX_BITS-1:0] robIdxIn;
    logic [ARCH_BITS-1:0]    pcIn;
    logic [REG_IDX_BITS-1:0] dstRegIn;
    logic [ARCH_BITS-1:0]    data1In;
    logic [ARCH_BITS-1:0]    data2In;
    logic                    stallIn;
    logic                    flushIn;

    // Result side
    logic                    validOut;
    logic [OPCODE_BITS-1:0]  opcodeOut;
    logic [ROB_IDX_BITS-1:0] robIdxOut;
    logic [ARCH_BITS-1:0]    pcOut;
    logic [REG_IDX_BITS-1:0] dstRegOut;
    logic [ARCH_BITS-1:0]    resH;
    logic [ARCH_BITS-1:0]    resL;
    logic [CNT_BITS-1:0]     inflight;
    logic                    busy;

    modport master (
        output validIn, signedIn, opcodeIn, robIdxIn, pcIn, dstRegIn,
               data1In, data2In, stallIn, flushIn,
        input  validOut, opcodeOut, robIdxOut, pcOut, dstRegOut,
               resH, resL, inflight, busy
    );

    modport slave (
        input  validIn, signedIn, opcodeIn, robIdxIn, pcIn, dstRegIn,
               data1In, data2In, stallIn, flushIn,
        output validOut, opcodeOut, robIdxOut, pcOut, dstRegOut,
               resH, resL, inflight, busy
    );
endinterface

// File: rtl/mult_pipe.sv
// mult_pipe: parametrised pipelined integer multiplier (full 2*ARCH_BITS product).
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - mult_pipe_if.slave: op/operands/metadata in, stall/flush in,
//          registered result + metadata out, inflight count and busy out.
// An op accepted at edge N is on the outputs after edge N+STAGES-1. Stall
// freezes every stage, flush kills every stage (and the op presented with it).
// Invalid stages always carry OPCODE_NOP and zero payload, so the outputs are
// idle-clean whenever validOut is low.
module mult_pipe #(
    parameter int unsigned ARCH_BITS    = 32,
    parameter int unsigned STAGES       = 4,
    parameter int unsigned OPCODE_BITS  = 6,
    parameter int unsigned ROB_IDX_BITS = 4,
    parameter int unsigned REG_IDX_BITS = 5,
    parameter int unsigned OPCODE_NOP   = 0,
    parameter int unsigned CNT_BITS     = $clog2(STAGES + 1)
) (
    input  logic         clk,
    input  logic         rst,
    mult_pipe_if.slave   bus
);

    localparam int unsigned PROD_BITS = 2 * ARCH_BITS;
    localparam logic [OPCODE_BITS-1:0] NOP_OP = OPCODE_BITS'(OPCODE_NOP);

    // Metadata travelling alongside the operands/product
    typedef struct packed {
        logic [OPCODE_BITS-1:0]  opcode;
        logic [ROB_IDX_BITS-1:0] rob_idx;
        logic [ARCH_BITS-1:0]    pc;
        logic [REG_IDX_BITS-1:0] dst_reg;
    } meta_t;

    localparam meta_t META_IDLE = '{opcode: NOP_OP, rob_idx: '0, pc: '0, dst_reg: '0};

    // Sign- or zero-extend both operands to full width; the truncated
    // 2W x 2W product is then the exact 2W-bit result in either mode.
    function automatic logic [PROD_BITS-1:0] mul_ext(
        input logic                 sgn,
        input logic [ARCH_BITS-1:0] a,
        input logic [ARCH_BITS-1:0] b
    );
        logic [PROD_BITS-1:0] ea;
        logic [PROD_BITS-1:0] eb;
        ea = {{ARCH_BITS{sgn & a[ARCH_BITS-1]}}, a};
        eb = {{ARCH_BITS{sgn & b[ARCH_BITS-1]}}, b};
        return ea * eb;
    endfunction

    logic                 w_accept;
    logic                 w_advance;
    logic                 w_leave;
    meta_t                w_in_meta;
    logic [PROD_BITS-1:0] w_res;
    logic [CNT_BITS-1:0]  w_cnt_nxt;

    logic [STAGES-1:0]    r_vld;
    meta_t                r_meta [STAGES];
    logic [CNT_BITS-1:0]  r_cnt;
    logic                 r_busy;

    // Flush overrides stall: a flushing edge always clocks the pipe (to empty)
    assign w_accept  = bus.validIn && !bus.stallIn && !bus.flushIn;
    assign w_advance = !bus.stallIn || bus.flushIn;
    assign w_leave   = r_vld[STAGES-1] && !bus.stallIn;

    // Metadata for stage 0: real op or an idle bubble
    always_comb begin
        w_in_meta = META_IDLE;
        if (w_accept) begin
            w_in_meta.opcode  = bus.opcodeIn;
            w_in_meta.rob_idx = bus.robIdxIn;
            w_in_meta.pc      = bus.pcIn;
            w_in_meta.dst_reg = bus.dstRegIn;
        end
    end

    // Valid bits and metadata shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_meta[i] <= META_IDLE;
            end
        end else if (w_advance) begin
            r_vld[0]  <= w_accept;
            r_meta[0] <= w_in_meta;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1] && !bus.flushIn;
                r_meta[i] <= (r_vld[i-1] && !bus.flushIn) ? r_meta[i-1] : META_IDLE;
            end
        end
    end

    // Product datapath
    generate
        if (STAGES == 1) begin : g_single
            logic [PROD_BITS-1:0] w_prod;
            logic [PROD_BITS-1:0] r_prod;

            // Only one stage: multiply straight off the inputs and register it
            assign w_prod = mul_ext(bus.signedIn, bus.data1In, bus.data2In);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_prod <= '0;
                end else if (w_advance) begin
                    r_prod <= w_accept ? w_prod : '0;
                end
            end

            assign w_res = r_prod;
        end else begin : g_multi
            logic                 r_sgn;
            logic [ARCH_BITS-1:0] r_d1;
            logic [ARCH_BITS-1:0] r_d2;
            logic [PROD_BITS-1:0] w_prod;
            logic [PROD_BITS-1:0] r_prod [1:STAGES-1];

            // Stage 0 holds the operands; stage 1 onward holds the product
            assign w_prod = mul_ext(r_sgn, r_d1, r_d2);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sgn <= 1'b0;
                    r_d1  <= '0;
                    r_d2  <= '0;
                    for (int i = 1; i < STAGES; i++) begin
                        r_prod[i] <= '0;
                    end
                end else if (w_advance) begin
                    r_sgn     <= w_accept && bus.signedIn;
                    r_d1      <= w_accept ? bus.data1In : '0;
                    r_d2      <= w_accept ? bus.data2In : '0;
                    r_prod[1] <= (r_vld[0] && !bus.flushIn) ? w_prod : '0;
                    for (int i = 2; i < STAGES; i++) begin
                        r_prod[i] <= (r_vld[i-1] && !bus.flushIn) ? r_prod[i-1] : '0;
                    end
                end
            end

            assign w_res = r_prod[STAGES-1];
        end
    endgenerate

    // In-flight op count: +1 on accept, -1 on a valid op leaving the last stage
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.flushIn) begin
            w_cnt_nxt = '0;
        end else if (w_accept && !w_leave) begin
            w_cnt_nxt = r_cnt + CNT_BITS'(1);
        end else if (!w_accept && w_leave) begin
            w_cnt_nxt = r_cnt - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    // Outputs come straight from the last stage registers
    assign bus.validOut  = r_vld[STAGES-1];
    assign bus.opcodeOut = r_meta[STAGES-1].opcode;
    assign bus.robIdxOut = r_meta[STAGES-1].rob_idx;
    assign bus.pcOut     = r_meta[STAGES-1].pc;
    assign bus.dstRegOut = r_meta[STAGES-1].dst_reg;
    assign bus.resH      = w_res[PROD_BITS-1:ARCH_BITS];
    assign bus.resL      = w_res[ARCH_BITS-1:0];
    assign bus.inflight  = r_cnt;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed stimulus for mult_pipe, checked every cycle against
// a queue-of-ops model (each op ages one step per non-stalled edge) plus
// hand-computed literal expectations at key points.
module tb_mult_pipe;

    localparam int unsigned W    = 32;
    localparam int unsigned S    = 4;
    localparam int unsigned OPW  = 6;
    localparam int unsigned ROBW = 4;
    localparam int unsigned REGW = 5;
    localparam int unsigned CW   = $clog2(S + 1);

    logic clk;
    logic rst;

    mult_pipe_if #(.ARCH_BITS(W), .STAGES(S), .OPCODE_BITS(OPW),
                   .ROB_IDX_BITS(ROBW), .REG_IDX_BITS(REGW), .CNT_BITS(CW)) bus ();

    mult_pipe #(.ARCH_BITS(W), .STAGES(S), .OPCODE_BITS(OPW), .ROB_IDX_BITS(ROBW),
                .REG_IDX_BITS(REGW), .OPCODE_NOP(0), .CNT_BITS(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int unsigned     age;
        logic [OPW-1:0]  op;
        logic [ROBW-1:0] rob;
        logic [W-1:0]    pc;
        logic [REGW-1:0] dst;
        logic [2*W-1:0]  prod;
    } mop_t;

    mop_t mq[$];
    mop_t nq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Model: ops age by one on every non-stalled edge; the op of age S-1 is on the outputs
    initial begin
        mop_t m;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst || bus.flushIn) begin
                mq.delete();
            end else if (!bus.stallIn) begin
                nq.delete();
                foreach (mq[i]) begin
                    m = mq[i];
                    m.age++;
                    if (m.age < S) nq.push_back(m);
                end
                if (bus.validIn) begin
                    m.age  = 0;
                    m.op   = bus.opcodeIn;
                    m.rob  = bus.robIdxIn;
                    m.pc   = bus.pcIn;
                    m.dst  = bus.dstRegIn;
                    m.prod = ref_prod(bus.signedIn, bus.data1In, bus.data2In);
                    nq.push_back(m);
                end
                mq = nq;
            end
        end
    end

    // Compare every cycle, away from the active edge
    initial begin
        logic           e_vld;
        logic [OPW-1:0] e_op;
        logic [ROBW-1:0] e_rob;
        logic [W-1:0]   e_pc;
        logic [REGW-1:0] e_dst;
        logic [2*W-1:0] e_prod;
        forever begin
            @(negedge clk);
            e_vld = 1'b0; e_op = '0; e_rob = '0; e_pc = '0; e_dst = '0; e_prod = '0;
            foreach (mq[i]) begin
                if (mq[i].age == S - 1) begin
                    e_vld = 1'b1; e_op = mq[i].op; e_rob = mq[i].rob;
                    e_pc = mq[i].pc; e_dst = mq[i].dst; e_prod = mq[i].prod;
                end
            end
            chk("m_validOut",  64'(bus.validOut),  64'(e_vld));
            chk("m_opcodeOut", 64'(bus.opcodeOut), 64'(e_op));
            chk("m_robIdxOut", 64'(bus.robIdxOut), 64'(e_rob));
            chk("m_pcOut",     64'(bus.pcOut),     64'(e_pc));
            chk("m_dstRegOut", 64'(bus.dstRegOut), 64'(e_dst));
            chk("m_product",   {bus.resH, bus.resL}, e_prod);
            chk("m_inflight",  64'(bus.inflight),  64'(mq.size()));
            chk("m_busy",      64'(bus.busy),      64'(mq.size() != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [ROBW-1:0] rob, input logic [OPW-1:0] op);
        bus.validIn  = 1'b1;
        bus.signedIn = s;
        bus.data1In  = a;
        bus.data2In  = b;
        bus.robIdxIn = rob;
        bus.opcodeIn = op;
        bus.pcIn     = 32'h1000 + 32'(rob) * 4;
        bus.dstRegIn = REGW'(rob) + 5'd1;
        tick();
    endtask

    task automatic idle();
        bus.validIn = 1'b0;
        tick();
    endtask

    task automatic lit_out(input string name, input logic v, input logic [ROBW-1:0] rob,
                           input logic [31:0] h, input logic [31:0] l);
        chk({name, "_valid"}, 64'(bus.validOut), 64'(v));
        chk({name, "_rob"},   64'(bus.robIdxOut), 64'(rob));
        chk({name, "_resH"},  64'(bus.resH), 64'(h));
        chk({name, "_resL"},  64'(bus.resL), 64'(l));
    endtask

    initial begin
        rst = 1'b0;
        bus.validIn = 1'b0; bus.signedIn = 1'b0; bus.opcodeIn = '0; bus.robIdxIn = '0;
        bus.pcIn = '0; bus.dstRegIn = '0; bus.data1In = '0; bus.data2In = '0;
        bus.stallIn = 1'b0; bus.flushIn = 1'b0;

        // Reset state
        tick();
        lit_out("rst", 1'b0, 4'd0, 32'd0, 32'd0);
        chk("rst_opcode", 64'(bus.opcodeOut), 64'd0);
        chk("rst_inflight", 64'(bus.inflight), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Unsigned 0xFFFFFFFF * 2, latency and isolation
        drive(1'b0, 32'hFFFF_FFFF, 32'h2, 4'd3, 6'd9);
        chk("t1_lat0", 64'(bus.validOut), 64'd0);
        idle(); chk("t1_lat1", 64'(bus.validOut), 64'd0);
        idle(); chk("t1_lat2", 64'(bus.validOut), 64'd0);
        idle(); lit_out("t1", 1'b1, 4'd3, 32'h1, 32'hFFFF_FFFE);
        idle(); chk("t1_after", 64'(bus.validOut), 64'd0);

        // Signed -1 * 2
        drive(1'b1, 32'hFFFF_FFFF, 32'h2, 4'd2, 6'd10);
        idle(); idle(); idle();
        lit_out("t2", 1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        idle();

        // Back-to-back, in order with no gaps
        drive(1'b0, 32'd3, 32'd5, 4'd0, 6'd1);
        drive(1'b1, 32'hFFFF_FFFE, 32'd7, 4'd1, 6'd2);
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd2, 6'd3);
        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 6'd4);
        lit_out("b2b0", 1'b1, 4'd0, 32'd0, 32'd15);
        chk("b2b_inflight4", 64'(bus.inflight), 64'd4);
        idle(); lit_out("b2b1", 1'b1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
        idle(); lit_out("b2b2", 1'b1, 4'd2, 32'h4000_0000, 32'd0);
        idle(); lit_out("b2b3", 1'b1, 4'd3, 32'hFFFF_FFFE, 32'd1);
        chk("b2b_inflight1", 64'(bus.inflight), 64'd1);
        idle();
        chk("b2b_drained", 64'(bus.inflight), 64'd0);
        chk("b2b_busy", 64'(bus.busy), 64'd0);

        // Stall with 2 ops in flight; validIn during stall is ignored
        drive(1'b0, 32'h1234, 32'h10, 4'd5, 6'd11);
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 6'd12);
        bus.stallIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'hDEAD, 32'hBEEF, 4'd9, 6'd13);
            chk("stall_inflight", 64'(bus.inflight), 64'd2);
        end
        bus.stallIn = 1'b0;
        idle();
        idle(); lit_out("stA", 1'b1, 4'd5, 32'd0, 32'h12340);
        bus.stallIn = 1'b1;
        idle(); lit_out("stA_hold", 1'b1, 4'd5, 32'd0, 32'h12340);
        idle();
        bus.stallIn = 1'b0;
        idle(); lit_out("stB", 1'b1, 4'd6, 32'd0, 32'd1);
        idle(); chk("st_drained", 64'(bus.inflight), 64'd0);

        // Flush with validIn (and stall) while 3 ops in flight
        drive(1'b0, 32'd1, 32'd2, 4'd1, 6'd5);
        drive(1'b0, 32'd3, 32'd4, 4'd2, 6'd6);
        drive(1'b0, 32'd5, 32'd6, 4'd3, 6'd7);
        chk("fl_pre", 64'(bus.inflight), 64'd3);
        bus.flushIn = 1'b1;
        bus.stallIn = 1'b1;
        drive(1'b0, 32'd7, 32'd8, 4'd4, 6'd8);
        bus.flushIn = 1'b0;
        bus.stallIn = 1'b0;
        chk("fl_inflight", 64'(bus.inflight), 64'd0);
        for (int i = 0; i < 5; i++) begin
            idle(); chk("fl_quiet", 64'(bus.validOut), 64'd0);
        end

        // Asynchronous reset mid-cycle with a valid result showing
        drive(1'b0, 32'd2, 32'd3, 4'd7, 6'd14);
        drive(1'b0, 32'd4, 32'd5, 4'd8, 6'd15);
        drive(1'b0, 32'd6, 32'd7, 4'd9, 6'd16);
        idle(); chk("ar_pre", 64'(bus.validOut), 64'd1);
        #2 rst = 1'b0;
        #1;
        lit_out("ar", 1'b0, 4'd0, 32'd0, 32'd0);
        chk("ar_opcode", 64'(bus.opcodeOut), 64'd0);
        chk("ar_inflight", 64'(bus.inflight), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b0, 32'h1_0000, 32'h1_0000, 4'd10, 6'd17);
        idle(); idle(); idle();
        lit_out("ar_new", 1'b1, 4'd10, 32'd1, 32'd0);
        idle(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Parametrised pipelined integer multiplier for the execute cluster; next generation of the fixed 4-stage multiplier.
- Configurable depth and width, per-op signed/unsigned mode, per-stage valid tracking, global stall and flush.
- Full 2*ARCH_BITS product; ROB index, PC and destination register travel alongside the operands to writeback/ROB.
- Sits between the issue stage and the CDB/ROB arbiter.

Parameters:
- ARCH_BITS, 32, operand width; product is 2*ARCH_BITS.
- STAGES, 4, pipeline depth in cycles, legal range 1..16.
- OPCODE_BITS, 6, opcode width.
- ROB_IDX_BITS, 4, ROB index width.
- REG_IDX_BITS, 5, register index width.
- OPCODE_NOP, 0, opcode driven when no valid op is at the output.
- CNT_BITS, $clog2(STAGES+1), width of inflight.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- validIn  in  1  op present on inputs this cycle.
- signedIn  in  1  1 = two's-complement multiply, 0 = unsigned.
- opcodeIn  in  OPCODE_BITS  opcode tag.
- robIdxIn  in  ROB_IDX_BITS  ROB entry.
- pcIn  in  ARCH_BITS  PC of op.
- dstRegIn  in  REG_IDX_BITS  destination register.
- data1In  in  ARCH_BITS  multiplicand.
- data2In  in  ARCH_BITS  multiplier.
- stallIn  in  1  hold entire pipeline.
- flushIn  in  1  kill all in-flight ops.
- validOut  out  1  result valid.
- opcodeOut  out  OPCODE_BITS  opcode of result.
- robIdxOut  out  ROB_IDX_BITS  ROB entry of result.
- pcOut  out  ARCH_BITS  PC of result.
- dstRegOut  out  REG_IDX_BITS  destination of result.
- resH  out  ARCH_BITS  product bits [2*ARCH_BITS-1:ARCH_BITS].
- resL  out  ARCH_BITS  product bits [ARCH_BITS-1:0].
- inflight  out  CNT_BITS  count of valid ops in pipeline.
- busy  out  1  inflight != 0.

Behaviour:
- Reset (rst low, asynchronous): all stage valid bits 0; opcode regs = OPCODE_NOP; robIdx, pc, dstReg, data and product regs 0; inflight 0.
- Outputs at reset: validOut 0, opcodeOut OPCODE_NOP, all other outputs 0.
- Reset asserted mid-operation discards all ops with no partial output. The first op can be accepted on the first edge after rst deasserts.
- Pipeline: STAGES register stages. Stage 0 captures inputs on validIn && !stallIn && !flushIn.
- Latency is exactly STAGES edges with no stall: an op accepted at edge N appears on outputs after edge N+STAGES-1, visible during cycle N+STAGES-1..N+STAGES.
- Throughput is one op per cycle.
- Product arithmetic:
  - Computed from the operands registered in stage 0.
  - The result is registered in the final stage; outputs are purely registered.
  - Signed: both operands sign-extended to 2*ARCH_BITS. Unsigned: zero-extended. The product is truncated to 2*ARCH_BITS (exact, no overflow).
- Bubbles: a stage with valid=0 carries opcode OPCODE_NOP and zeroed payload.
- When validOut=0: opcodeOut=OPCODE_NOP, resH=resL=0, robIdxOut/pcOut/dstRegOut=0.
- Stall (stallIn=1, flushIn=0):
  - No stage advances; all registers hold; outputs hold stable.
  - validIn is ignored. Upstream must hold the op and reassert it.
  - A held valid output may persist multiple cycles; the consumer must sample it once.
- Flush (flushIn=1): all valid bits cleared at the next edge and inflight goes to 0. Flush overrides stall and validIn in the same cycle; the op presented with flush is dropped.
- inflight: +1 on accept, -1 when a valid op leaves the last stage. Both events in the same cycle leave it unchanged. Never exceeds STAGES.
- STAGES=1: a single register stage; product and metadata are registered one edge after accept.

Test Plan:
- Reset, then signedIn=0, data1In=0xFFFFFFFF, data2In=0x00000002, robIdxIn=3 at cycle 0 -> validOut=1 at cycle 4, resH=0x00000001, resL=0xFFFFFFFE, robIdxOut=3; validOut=0 at cycles 1-3 and 5.
- signedIn=1, data1In=0xFFFFFFFF (-1), data2In=0x00000002 -> resH=0xFFFFFFFF, resL=0xFFFFFFFE.
- Back-to-back ops on 4 consecutive cycles with robIdx 0..3 -> results in order on cycles 4..7 with no gaps; inflight reaches 4, then drains to 0; busy falls after cycle 7.
- Stall for 3 cycles while 2 ops are in flight -> outputs frozen for 3 cycles; both results arrive exactly 3 cycles late; validIn pulses during the stall are not counted or produced.
- flushIn with validIn in the same cycle while 3 ops are in flight -> no validOut for the next 5 cycles; inflight=0 after one edge.
- Assert rst low asynchronously mid-cycle with ops in flight -> validOut=0, opcodeOut=OPCODE_NOP immediately. After release, a new op (0x10000 * 0x10000 unsigned) yields resH=0x00000001, resL=0 after 4 cycles.
